fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, the first fetch address after reset.
REQ-002 SHALL have port CLK  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port RST_N  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port WPCIR  input  1  stall from ID controller; hold PC and IF/ID.
REQ-005 SHALL have port BRANCH  input  1  taken redirect from ID (branch, J, JAL, JR).
REQ-006 SHALL have port JUMP  input  1  redirect is J/JAL (absolute target).
REQ-007 SHALL have port JR  input  1  redirect is JR (register target).
REQ-008 SHALL have port JRADDR  input  32  forwarded rs value for JR.
REQ-009 SHALL have port SMC  input  1  EX store hits IDPC; refetch ID instruction.
REQ-010 SHALL have port SMC2  input  1  EX store hits IFPC; discard in-flight fetch word.
REQ-011 SHALL have port IREQ  output  1  instruction-memory request, one-cycle pulse.
REQ-012 SHALL have port IADDR  output  32  request address, valid with IREQ.
REQ-013 SHALL have port IRDATA  input  32  returned instruction word.
REQ-014 SHALL have port IVALID  input  1  IRDATA valid; one or more cycles after IREQ.
REQ-015 SHALL have port IFPC  output  32  PC of the instruction being fetched.
REQ-016 SHALL have port IDPC  output  32  PC of the instruction in ID.
REQ-017 SHALL have port IDIR  output  32  instruction register feeding ID.
REQ-018 SHALL have port IDVALID  output  1  IDIR holds a real instruction (0 = bubble).

Function
REQ-019 SHALL implement FSM states REQ, WAIT, HOLD, DROP; at most one outstanding memory request.
REQ-020 REQ: SHALL assert IREQ with IADDR=IFPC for one cycle, then go to WAIT.
REQ-021 WAIT with IVALID and no WPCIR: SHALL load IDIR<=IRDATA, IDPC<=IFPC, IDVALID<=1, IFPC<=IFPC+4 (mod 2^32), go to REQ.
REQ-022 WAIT with IVALID and WPCIR: SHALL capture IRDATA into an internal buffer, go to HOLD.
REQ-023 HOLD: SHALL keep buffer while WPCIR=1; on first cycle WPCIR=0, load IF/ID from buffer as REQ-021 and go to REQ.
REQ-024 When WPCIR=0 and no word is delivered this cycle, SHALL load bubble: IDIR<=0, IDVALID<=0, IDPC unchanged.
REQ-025 When WPCIR=1, IDIR, IDPC, IDVALID, IFPC SHALL hold.
REQ-026 Redirect target: JR -> JRADDR; JUMP -> {IDPC+4[31:28], IDIR[25:0], 2'b00}; else IDPC+4+(sign-extended IDIR[15:0]<<2), 32-bit wrap.
REQ-027 BRANCH=1 and WPCIR=0: SHALL set IFPC<=target, load bubble into IF/ID, discard any buffer; no delay slot.
REQ-028 Redirect while a request is outstanding (WAIT, IVALID=0): SHALL go to DROP; DROP discards the next IVALID word, then goes to REQ.
REQ-029 Redirect in the same cycle IVALID arrives in WAIT: SHALL discard the word and go to REQ.
REQ-030 SMC=1: SHALL set IFPC<=IDPC, load bubble into IF/ID, discard buffer, enter DROP if outstanding else REQ; overrides WPCIR and BRANCH.
REQ-031 SMC2=1 (SMC=0): SHALL discard any buffered or same-cycle word for IFPC, keep IFPC, enter DROP if outstanding else REQ; IF/ID follows WPCIR.
REQ-032 Priority SHALL be SMC > WPCIR > BRANCH > SMC2 > normal; BRANCH with WPCIR=1 is ignored (controller reasserts).
REQ-033 IVALID in REQ or HOLD SHALL be ignored.

Reset
REQ-034 RST_N=0 SHALL immediately force IFPC=RESET_PC, IDPC=0, IDIR=0, IDVALID=0, IREQ=0, buffer cleared, state REQ.
REQ-035 First IREQ SHALL occur on the first rising CLK edge after RST_N rises; reset mid-request drops the outstanding response.

Verification
REQ-036 Reset release, memory returns 32'h2008_0005 one cycle after IREQ -> IREQ/IADDR=0, then IDIR=32'h2008_0005, IDPC=0, IDVALID=1, IFPC=4.
REQ-037 Straight-line fetch of 4 words, 1-cycle latency -> IADDR 0,4,8,C; IDPC steps 0,4,8,C; bubbles between words.
REQ-038 WPCIR held 3 cycles while word at 8 returns -> HOLD, IF/ID frozen, word at 8 delivered on first unstalled cycle, no extra IREQ.
REQ-039 IDPC=0x10, IDIR=32'h1000_FFFE, BRANCH=1, request outstanding -> IFPC=0x0C, IDVALID=0, late word dropped, next IADDR=0x0C.
REQ-040 JR with JRADDR=0x40 and WPCIR=1 same cycle -> no redirect; JR repeated with WPCIR=0 -> IFPC=0x40.
REQ-041 IDPC=0x20, SMC=1 with WPCIR=1 -> IFPC=0x20, IDVALID=0, next IADDR=0x20; SMC2 alone -> IFPC refetched unchanged.

Source files
------------

// File: rtl/fetch_unit_if.sv
// Instruction-memory request/response bus for fetch_unit.
// IREQ/IADDR: one-cycle request; IRDATA/IVALID: returned word, later cycle.
interface fetch_unit_if;
   logic        IREQ;
   logic [31:0] IADDR;
   logic [31:0] IRDATA;
   logic        IVALID;

   modport master (
      output IREQ, IADDR,
      input  IRDATA, IVALID
   );

   modport slave (
      input  IREQ, IADDR,
      output IRDATA, IVALID
   );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: single outstanding request, IF/ID register.
// Ports: CLK/RST_N, ID controls (WPCIR, BRANCH, JUMP, JR, JRADDR),
// store-hazard kills (SMC, SMC2), imem bus, IFPC/IDPC/IDIR/IDVALID.
module fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic         CLK,
   input  logic         RST_N,
   input  logic         WPCIR,
   input  logic         BRANCH,
   input  logic         JUMP,
   input  logic         JR,
   input  logic [31:0]  JRADDR,
   input  logic         SMC,
   input  logic         SMC2,
   fetch_unit_if.master imem,
   output logic [31:0]  IFPC,
   output logic [31:0]  IDPC,
   output logic [31:0]  IDIR,
   output logic         IDVALID
);

   typedef enum logic [1:0] {
      ST_REQ,
      ST_WAIT,
      ST_HOLD,
      ST_DROP
   } state_t;

   state_t      r_state, w_state;
   logic        r_live;
   logic [31:0] r_ifpc, w_ifpc;
   logic [31:0] r_idpc, w_idpc;
   logic [31:0] r_idir, w_idir;
   logic        r_idv, w_idv;
   logic [31:0] r_buf, w_buf;

   logic        w_busy;
   logic        w_redir;
   logic [31:0] w_word;
   logic [31:0] w_pc4;
   logic [31:0] w_off;
   logic [31:0] w_target;

   // A response is still owed if a request goes out this cycle
   // or one is pending and has not arrived yet.
   assign w_busy = (r_state == ST_REQ) ||
                   (((r_state == ST_WAIT) || (r_state == ST_DROP)) &&
                    !imem.IVALID);

   assign w_redir = BRANCH && !WPCIR;
   assign w_word  = (r_state == ST_HOLD) ? r_buf : imem.IRDATA;
   assign w_pc4   = r_idpc + 32'd4;
   assign w_off   = {{14{r_idir[15]}}, r_idir[15:0], 2'b00};

   always_comb begin
      w_target = w_pc4 + w_off;
      if (JR)
         w_target = JRADDR;
      else if (JUMP)
         w_target = {w_pc4[31:28], r_idir[25:0], 2'b00};
   end

   always_comb begin
      w_state = r_state;
      w_ifpc  = r_ifpc;
      w_idpc  = r_idpc;
      w_idir  = r_idir;
      w_idv   = r_idv;
      w_buf   = r_buf;
      // The cycle after reset release only raises r_live.
      if (!r_live) begin
         w_state = ST_REQ;
      end else if (SMC) begin
         w_ifpc  = r_idpc;
         w_idir  = '0;
         w_idv   = 1'b0;
         w_buf   = '0;
         w_state = w_busy ? ST_DROP : ST_REQ;
      end else if (w_redir) begin
         w_ifpc  = w_target;
         w_idir  = '0;
         w_idv   = 1'b0;
         w_buf   = '0;
         w_state = w_busy ? ST_DROP : ST_REQ;
      end else if (SMC2) begin
         if (!WPCIR) begin
            w_idir = '0;
            w_idv  = 1'b0;
         end
         w_buf   = '0;
         w_state = w_busy ? ST_DROP : ST_REQ;
      end else begin
         if (!WPCIR) begin
            w_idir = '0;
            w_idv  = 1'b0;
         end
         unique case (r_state)
            ST_REQ: w_state = ST_WAIT;
            ST_WAIT: begin
               if (imem.IVALID) begin
                  if (WPCIR) begin
                     w_buf   = imem.IRDATA;
                     w_state = ST_HOLD;
                  end else begin
                     w_idir  = w_word;
                     w_idpc  = r_ifpc;
                     w_idv   = 1'b1;
                     w_ifpc  = r_ifpc + 32'd4;
                     w_state = ST_REQ;
                  end
               end
            end
            ST_HOLD: begin
               if (!WPCIR) begin
                  w_idir  = w_word;
                  w_idpc  = r_ifpc;
                  w_idv   = 1'b1;
                  w_ifpc  = r_ifpc + 32'd4;
                  w_buf   = '0;
                  w_state = ST_REQ;
               end
            end
            ST_DROP: begin
               if (imem.IVALID)
                  w_state = ST_REQ;
            end
         endcase
      end
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         r_state <= ST_REQ;
         r_live  <= 1'b0;
         r_ifpc  <= RESET_PC;
         r_idpc  <= '0;
         r_idir  <= '0;
         r_idv   <= 1'b0;
         r_buf   <= '0;
      end else begin
         r_state <= w_state;
         r_live  <= 1'b1;
         r_ifpc  <= w_ifpc;
         r_idpc  <= w_idpc;
         r_idir  <= w_idir;
         r_idv   <= w_idv;
         r_buf   <= w_buf;
      end
   end

   assign imem.IREQ  = r_live && (r_state == ST_REQ);
   assign imem.IADDR = r_ifpc;
   assign IFPC       = r_ifpc;
   assign IDPC       = r_idpc;
   assign IDIR       = r_idir;
   assign IDVALID    = r_idv;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a 1- or 2-cycle memory model.
// Cycle table of controls/expected outputs plus reset/latency sequences.
module tb_fetch_unit;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        wp = 0, br = 0, jm = 0, jr = 0, smc = 0, smc2 = 0;
   logic [31:0] jra = '0;
   logic [31:0] ifpc, idpc, idir;
   logic        idv;
   logic        lat2 = 1'b0;
   int          checks = 0;
   int          errors = 0;

   fetch_unit_if bus ();

   fetch_unit #(.RESET_PC(32'h0)) dut (
      .CLK(clk), .RST_N(rst_n), .WPCIR(wp), .BRANCH(br),
      .JUMP(jm), .JR(jr), .JRADDR(jra), .SMC(smc), .SMC2(smc2),
      .imem(bus), .IFPC(ifpc), .IDPC(idpc), .IDIR(idir),
      .IDVALID(idv)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] word(input logic [31:0] a);
      case (a)
         32'h0:   return 32'h2008_0005;
         32'h10:  return 32'h1000_FFFE;
         32'h40:  return 32'h1000_FFF7;
         default: return 32'hC000_0000 | a;
      endcase
   endfunction

   logic        mv1, mv2;
   logic [31:0] ma1, ma2;
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mv1 <= 1'b0; mv2 <= 1'b0; ma1 <= '0; ma2 <= '0;
      end else begin
         mv1 <= bus.IREQ; ma1 <= bus.IADDR;
         mv2 <= mv1;      ma2 <= ma1;
      end
   end
   assign bus.IVALID = lat2 ? mv2 : mv1;
   assign bus.IRDATA = word(lat2 ? ma2 : ma1);

   typedef struct {
      logic        wp, br, jm, jr;
      logic [31:0] jra;
      logic        smc, smc2;
      logic        ireq;
      logic [31:0] ifpc, idpc, idir;
      logic        idv;
   } vec_t;

   vec_t tbl[33];

   function automatic vec_t mk(
      input logic wp_, br_, jm_, jr_, input logic [31:0] jra_,
      input logic smc_, smc2_, ireq_,
      input logic [31:0] pc_, dpc_, dir_, input logic dv_);
      vec_t v;
      v.wp = wp_; v.br = br_; v.jm = jm_; v.jr = jr_; v.jra = jra_;
      v.smc = smc_; v.smc2 = smc2_; v.ireq = ireq_;
      v.ifpc = pc_; v.idpc = dpc_; v.idir = dir_; v.idv = dv_;
      return v;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", nm, act, exp);
      end
   endtask

   task automatic chk_reset(input string nm);
      chk({nm, "_ireq"}, {31'd0, bus.IREQ}, 32'd0);
      chk({nm, "_ifpc"}, ifpc, 32'h0);
      chk({nm, "_idpc"}, idpc, 32'h0);
      chk({nm, "_idir"}, idir, 32'h0);
      chk({nm, "_idv"}, {31'd0, idv}, 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1);
   end

   initial begin
      logic [129:0] act, exp;
      //           wp br jm jr jra    smc s2 | rq ifpc   idpc   idir          v
      tbl[0]  = mk(0, 0, 0, 0, 32'h0, 0, 0, 1, 32'h0,  32'h0,  32'h0,         0);
      tbl[1]  = mk(0, 0, 0, 0, 32'h0, 0, 0, 0, 32'h0,  32'h0,  32'h0,         0);
      tbl[2]  = mk(0, 0, 0, 0, 32'h0, 0, 0, 1, 32'h4,  32'h0,  32'h2008_0005, 1);
      tbl[3]  = mk(0, 0, 0, 0, 32'h0, 0, 0, 0, 32'h4,  32'h0,  32'h0,         0);
      tbl[4]  = mk(1, 0, 0, 0, 32'h0, 0, 0, 1, 32'h8,  32'h4,  32'hC000_0004, 1);
      tbl[5]  = mk(1, 0, 0, 0, 32'h0, 0, 0, 0, 32'h8,  32'h4,  32'hC000_0004, 1);
      tbl[6]  = mk(1, 0, 0, 0, 32'h0, 0, 0, 0, 32'h8,  32'h4,  32'hC000_0004, 1);
      tbl[7]  = mk(0, 0, 0, 0, 32'h0, 0, 0, 0, 32'h8,  32'h4,  32'hC000_0004, 1);
      tbl[8]  = mk(0, 0, 0, 0, 32'h0, 0, 0, 1, 32'hC,  32'h8,  32'hC000_0008, 1);
      tbl[9]  = mk(0, 0, 0, 0, 32'h0, 0, 0, 0, 32'hC,  32'h8,  32'h0,         0);
      tbl[10] = mk(0, 0, 0, 0, 32'h0, 0, 0, 1, 32'h10, 32'hC,  32'hC000_000C, 1);
      tbl[11] = mk(0, 0, 0, 0, 32'h0, 0, 0, 0, 32'h10, 32'hC,  32'h0,         0);
      tbl[12] = mk(0, 1, 0, 0, 32'h0, 0, 0, 1, 32'h14, 32'h10, 32'h1000_FFFE, 1);
      tbl[13] = mk(0, 0, 0, 0, 32'h0, 0, 0, 0, 32'hC,  32'h10, 32'h0,         0);
      tbl[14] = mk(0, 0, 0, 0, 32'h0, 0, 0, 1, 32'hC,  32'h10, 32'h0,         0);
      tbl[15] = mk(0, 0, 0, 0, 32'h0, 0, 0, 0, 32'hC,  32'h10, 32'h0,         0);
      tbl[16] = mk(1, 1, 0, 1, 32'h40, 0, 0, 1, 32'h10, 32'hC, 32'hC000_000C, 1);
      tbl[17] = mk(0, 1, 0, 1, 32'h40, 0, 0, 0, 32'h10, 32'hC, 32'hC000_000C, 1);
      tbl[18] = mk(0, 0, 0, 0, 32'h0, 0, 0, 1, 32'h40, 32'hC,  32'h0,         0);
      tbl[19] = mk(0, 0, 0, 0, 32'h0, 0, 0, 0, 32'h40, 32'hC,  32'h0,         0);
      tbl[20] = mk(0, 1, 0, 0, 32'h0, 0, 0, 1, 32'h44, 32'h40, 32'h1000_FFF7, 1);
      tbl[21] = mk(0, 0, 0, 0, 32'h0, 0, 0, 0, 32'h20, 32'h40, 32'h0,         0);
      tbl[22] = mk(0, 0, 0, 0, 32'h0, 0, 0, 1, 32'h20, 32'h40, 32'h0,         0);
      tbl[23] = mk(0, 0, 0, 0, 32'h0, 0, 0, 0, 32'h20, 32'h40, 32'h0,         0);
      tbl[24] = mk(1, 0, 0, 0, 32'h0, 1, 0, 1, 32'h24, 32'h20, 32'hC000_0020, 1);
      tbl[25] = mk(0, 0, 0, 0, 32'h0, 0, 0, 0, 32'h20, 32'h20, 32'h0,         0);
      tbl[26] = mk(0, 0, 0, 0, 32'h0, 0, 0, 1, 32'h20, 32'h20, 32'h0,         0);
      tbl[27] = mk(0, 0, 0, 0, 32'h0, 0, 1, 0, 32'h20, 32'h20, 32'h0,         0);
      tbl[28] = mk(0, 0, 0, 0, 32'h0, 0, 0, 1, 32'h20, 32'h20, 32'h0,         0);
      tbl[29] = mk(0, 0, 0, 0, 32'h0, 0, 0, 0, 32'h20, 32'h20, 32'h0,         0);
      tbl[30] = mk(0, 1, 1, 0, 32'h0, 0, 0, 1, 32'h24, 32'h20, 32'hC000_0020, 1);
      tbl[31] = mk(0, 0, 0, 0, 32'h0, 0, 0, 0, 32'h80, 32'h20, 32'h0,         0);
      tbl[32] = mk(0, 0, 0, 0, 32'h0, 0, 0, 1, 32'h80, 32'h20, 32'h0,         0);

      repeat (3) @(negedge clk);
      chk_reset("reset");
      rst_n = 1'b1;

      for (int i = 0; i < 33; i++) begin
         @(negedge clk);
         wp = tbl[i].wp; br = tbl[i].br; jm = tbl[i].jm;
         jr = tbl[i].jr; jra = tbl[i].jra;
         smc = tbl[i].smc; smc2 = tbl[i].smc2;
         act = {bus.IREQ, bus.IADDR, ifpc, idpc, idir, idv};
         exp = {tbl[i].ireq, tbl[i].ifpc, tbl[i].ifpc, tbl[i].idpc,
                tbl[i].idir, tbl[i].idv};
         checks++;
         if (act !== exp) begin
            errors++;
            $display("FAIL row%0d actual=%h required=%h", i, act, exp);
         end
      end

      // Asynchronous reset mid-run, then redirect during a 2-cycle wait.
      @(negedge clk);
      wp = 0; br = 0; jm = 0; jr = 0; jra = '0; smc = 0; smc2 = 0;
      rst_n = 1'b0;
      lat2  = 1'b1;
      #1;
      chk_reset("async_reset");
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("l2_c0_ireq", {31'd0, bus.IREQ}, 32'd1);
      chk("l2_c0_iaddr", bus.IADDR, 32'h0);
      @(negedge clk);
      chk("l2_c1_ivalid", {31'd0, bus.IVALID}, 32'd0);
      br = 1; jr = 1; jra = 32'h100;
      @(negedge clk);
      br = 0; jr = 0; jra = '0;
      chk("l2_c2_ifpc", ifpc, 32'h100);
      chk("l2_c2_ireq", {31'd0, bus.IREQ}, 32'd0);
      @(negedge clk);
      chk("l2_c3_ireq", {31'd0, bus.IREQ}, 32'd1);
      chk("l2_c3_iaddr", bus.IADDR, 32'h100);
      chk("l2_c3_idv", {31'd0, idv}, 32'd0);
      chk("l2_c3_idir", idir, 32'h0);
      repeat (3) @(negedge clk);
      chk("l2_c6_idpc", idpc, 32'h100);
      chk("l2_c6_idir", idir, 32'hC000_0100);
      chk("l2_c6_idv", {31'd0, idv}, 32'd1);
      chk("l2_c6_ifpc", ifpc, 32'h104);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk_reset("midreq_reset");
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("rel_ireq", {31'd0, bus.IREQ}, 32'd1);
      chk("rel_iaddr", bus.IADDR, 32'h0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
